// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the padder, the message scheduler and the compressor.
// master = upstream/downstream environment side, slave = scheduler side.
interface sha256_msg_sched_if;
    logic                  in_valid;
    logic                  in_ready;
    logic [0:15][31:0]     block;
    logic                  out_valid;
    logic                  out_ready;
    logic [0:63][31:0]     W;

    modport master (
        output in_valid, block, out_ready,
        input  in_ready, out_valid, W
    );

    modport slave (
        input  in_valid, block, out_ready,
        output in_ready, out_valid, W
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: latches a 16-word block, expands W[16..63] one
// word per cycle, then holds the full 64-word schedule until it is taken.
module sha256_msg_sched (
    input  logic               clk,
    input  logic               reset_n,
    sha256_msg_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [0:63][31:0] wsched_q, wsched_d;
    logic [31:0]       w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // New schedule word for the current index; all taps lie below idx, so they
    // are always words already written for this block.
    always_comb begin
        w_new = sig1(wsched_q[idx_q - 6'd2]) + wsched_q[idx_q - 6'd7]
              + sig0(wsched_q[idx_q - 6'd15]) + wsched_q[idx_q - 6'd16];
    end

    // Next-state, index and schedule-array update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wsched_d = wsched_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Clearing the upper words keeps a previous schedule from
                    // ever showing through while the new one is built.
                    for (int i = 0; i < 64; i++) begin
                        wsched_d[i] = (i < 16) ? bus.block[i % 16] : 32'd0;
                    end
                    idx_d   = 6'd16;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wsched_d[idx_q] = w_new;
                idx_d           = idx_q + 6'd1;   // wraps to 0 after 63
                if (idx_q == 6'd63) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, index and schedule registers; reset clears the whole array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            wsched_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wsched_q <= wsched_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.W         = wsched_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched with a queue-based scoreboard.
module tb_sha256_msg_sched;

    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] sched_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    sched_t exp_q[$];
    int     acc_q[$];

    sha256_msg_sched_if bus();

    sha256_msg_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t model(input blk_t b);
        sched_t w;
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic chk_arr(input string nm, input sched_t act, input sched_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            for (int i = 0; i < 64; i++) begin
                if (act[i] !== req[i]) begin
                    $display("FAIL %s: W[%0d] got %h, required %h", nm, i, act[i], req[i]);
                    break;
                end
            end
        end
    endtask

    // Scoreboard monitor: every output transfer pops and checks one schedule.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got a transfer, required none");
            end else begin
                chk_arr("sched_transfer", bus.W, exp_q.pop_front());
            end
        end
    end

    // Acceptance logger for the throughput check.
    always @(negedge clk) begin
        if (reset_n && bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end

    // Offer one block; returns after the accepting edge (+1).
    task automatic send(input blk_t b);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
        bus.block    = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_take", {31'd0, bus.out_valid}, 32'd0);
        chk("in_ready_after_take",  {31'd0, bus.in_ready},  32'd1);
    endtask

    task automatic chk_abc_words(input string tag);
        chk({tag, "_W16"}, bus.W[16], 32'h61626380);
        chk({tag, "_W17"}, bus.W[17], 32'h000F0000);
        chk({tag, "_W18"}, bus.W[18], 32'h7DA86405);
        chk({tag, "_W63"}, bus.W[63], 32'h12B1EDEB);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t   abc, zero, junk;
        sched_t snap, zsched;
        int     lat;
        logic   stable;

        abc      = '0;
        abc[0]   = 32'h61626380;
        abc[15]  = 32'h00000018;
        zero     = '0;
        zsched   = '0;
        for (int i = 0; i < 16; i++) junk[i] = 32'hDEAD0000 + i;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.block     = '0;

        // Reset state
        #23;
        chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_arr("reset_W", bus.W, zsched);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // "abc" vector with latency and backpressure
        send(abc);
        wait_valid(lat);
        chk("abc_latency", lat, 48);
        for (int i = 0; i < 16; i++) chk($sformatf("abc_W%0d", i), bus.W[i], abc[i]);
        chk_abc_words("abc");
        snap   = bus.W;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.W !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        chk("backpressure_stable", {31'd0, stable}, 32'd1);
        release_out();

        // All-zero block
        send(zero);
        wait_valid(lat);
        chk("zero_latency", lat, 48);
        chk_arr("zero_W", bus.W, zsched);
        release_out();

        // Inputs ignored during expansion
        send(abc);
        repeat (10) @(posedge clk);
        #1;
        bus.block     = junk;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("ignored_out_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_valid(lat);
        chk("ignored_latency", lat, 37);
        chk("ignored_W1", bus.W[1], 32'h0);
        chk_abc_words("ignored");
        release_out();

        // Asynchronous reset mid-expansion
        send(abc);
        repeat (29) @(posedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        chk("midreset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_arr("midreset_W", bus.W, zsched);
        void'(exp_q.pop_back());
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(abc);
        wait_valid(lat);
        chk("after_reset_latency", lat, 48);
        chk_abc_words("after_reset");
        release_out();

        // Back-to-back with out_ready tied high
        acc_q.delete();
        bus.out_ready = 1'b1;
        bus.block     = abc;
        bus.in_valid  = 1'b1;
        exp_q.push_back(model(abc));
        @(posedge clk); #1;
        bus.block = zero;
        exp_q.push_back(model(zero));
        lat = 0;
        while (acc_q.size() < 2 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 50);
        lat = 0;
        while (exp_q.size() != 0 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        bus.out_ready = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
